// File: rtl/pwm_dec_pkg.sv
// Shared types for the PWM sample decoder: FSM state encoding, sample width
// and the output saturation helper.
package pwm_dec_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } state_t;

    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the looped-back PWM line plus rising-edge detect.
module pwm_edge_sync (
    input  logic clk,
    input  logic gated_reset,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_pwm;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/pwm_sample_decoder.sv
// Measures PWM duty per frame (rising edge to rising edge) and emits an 8-bit
// sample with valid/ready handshake. Optional error counter: PWM_DEC_ERRCNT_EN.
module pwm_sample_decoder
    import pwm_dec_pkg::*;
#(
    parameter int PERIOD  = 256,
    parameter int TIMEOUT = 512
) (
    input  logic                clk,
    input  logic                gated_reset,
    input  logic                pwm_in,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                frame_err,
    output logic                overrun,
    output logic [SAMPLE_W-1:0] err_count
);

    localparam int CW  = $clog2(TIMEOUT) + 1;
    localparam int PW  = $clog2(PERIOD);
    localparam int LSH = (PW <= SAMPLE_W) ? SAMPLE_W - PW : 0;
    localparam int RSH = (PW >  SAMPLE_W) ? PW - SAMPLE_W : 0;
    localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    logic w_level;
    logic w_rise;

    pwm_edge_sync u_sync (
        .clk         (clk),
        .gated_reset (gated_reset),
        .i_pwm       (pwm_in),
        .o_level     (w_level),
        .o_rise      (w_rise)
    );

    state_t              r_state;
    logic [CW-1:0]       r_cycle_cnt;
    logic [CW-1:0]       r_high_cnt;
    logic [SAMPLE_W-1:0] r_stuck_val;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid;
    logic                r_frame_err;
    logic                r_overrun;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_cycle_nxt;
    logic [CW-1:0]       w_high_nxt;
    logic [SAMPLE_W-1:0] w_stuck_nxt;
    logic                w_emit;
    logic                w_emit_err;
    logic [SAMPLE_W-1:0] w_emit_val;
    logic [31:0]         w_scaled;

    // 256/PERIOD scaling is a pure shift since PERIOD is a power of two
    assign w_scaled = (32'(r_high_cnt) << LSH) >> RSH;

    always_comb begin
        w_state_nxt = r_state;
        w_cycle_nxt = r_cycle_cnt;
        w_high_nxt  = r_high_cnt;
        w_stuck_nxt = r_stuck_val;
        w_emit      = 1'b0;
        w_emit_err  = 1'b0;
        w_emit_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                    w_cycle_nxt = ONE_C;
                    w_high_nxt  = ONE_C;
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    w_emit      = 1'b1;
                    w_emit_val  = sat_sample(w_scaled);
                    w_emit_err  = (r_cycle_cnt != PERIOD_C);
                    w_cycle_nxt = ONE_C;
                    w_high_nxt  = ONE_C;
                end else if (r_cycle_cnt == TIMEOUT_C) begin
                    w_state_nxt = ST_STUCK;
                    w_emit      = 1'b1;
                    w_emit_val  = {SAMPLE_W{w_level}};
                    w_emit_err  = 1'b1;
                    w_stuck_nxt = {SAMPLE_W{w_level}};
                    w_cycle_nxt = ONE_C;
                end else begin
                    w_cycle_nxt = r_cycle_cnt + ONE_C;
                    w_high_nxt  = r_high_cnt + {{(CW-1){1'b0}}, w_level};
                end
            end
            ST_STUCK: begin
                // constant re-emitted once per nominal frame until the line moves
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                    w_cycle_nxt = ONE_C;
                    w_high_nxt  = ONE_C;
                end else if (r_cycle_cnt == PERIOD_C) begin
                    w_emit      = 1'b1;
                    w_emit_val  = r_stuck_val;
                    w_cycle_nxt = ONE_C;
                end else begin
                    w_cycle_nxt = r_cycle_cnt + ONE_C;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            r_state     <= ST_IDLE;
            r_cycle_cnt <= '0;
            r_high_cnt  <= '0;
            r_stuck_val <= '0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cycle_cnt <= w_cycle_nxt;
            r_high_cnt  <= w_high_nxt;
            r_stuck_val <= w_stuck_nxt;
            if (w_emit) begin
                r_sample <= w_emit_val;
                r_valid  <= 1'b1;
            end else if (r_valid && sample_ready) begin
                r_valid  <= 1'b0;
            end
            r_frame_err <= w_emit & w_emit_err;
            r_overrun   <= w_emit & r_valid & ~sample_ready;
        end
    end

`ifdef PWM_DEC_ERRCNT_EN
    logic [SAMPLE_W-1:0] r_err_cnt;

    // simultaneous frame_err and overrun count once
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset)
            r_err_cnt <= '0;
        else if ((r_frame_err || r_overrun) && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = '0;
`endif

    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign frame_err    = r_frame_err;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Directed + randomized frame stimulus against a frame-level reference model.
module tb_pwm_sample_decoder;

    localparam int PERIOD  = 256;
    localparam int TIMEOUT = 512;

    logic       clk = 1'b0;
    logic       gated_reset = 1'b0;
    logic       pwm_in = 1'b0;
    logic       sample_ready = 1'b1;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       frame_err;
    logic       overrun;
    logic [7:0] err_count;

    pwm_sample_decoder #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .gated_reset  (gated_reset),
        .pwm_in       (pwm_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    // expected loads keyed by the clock edge at which they must appear
    logic [7:0] exp_s[int];
    bit         exp_f[int];

    bit         mdl_valid = 1'b0;
    logic [7:0] mdl_sample = 8'd0;
    int         mdl_err = 0;
    bit         have_prev = 1'b0;
    int         prev_l = 0;
    int         prev_h = 0;

    function automatic int frame_val(input int h);
        int v;
        v = h * 256 / PERIOD;
        return (v > 255) ? 255 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle();
        bit ld, fe, ov;
        ld = exp_s.exists(cyc);
        fe = 1'b0;
        ov = 1'b0;
        if (ld) begin
            ov         = mdl_valid && !sample_ready;
            fe         = exp_f[cyc];
            mdl_sample = exp_s[cyc];
            mdl_valid  = 1'b1;
            exp_s.delete(cyc);
            exp_f.delete(cyc);
        end else if (mdl_valid && sample_ready) begin
            mdl_valid = 1'b0;
        end
        chk("valid", 32'(sample_valid), 32'(mdl_valid));
        chk("sample", 32'(sample_out), 32'(mdl_sample));
        chk("frame_err", 32'(frame_err), 32'(fe));
        chk("overrun", 32'(overrun), 32'(ov));
`ifdef PWM_DEC_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(mdl_err));
`else
        chk("err_count", 32'(err_count), 32'd0);
`endif
        if ((fe || ov) && mdl_err < 255) mdl_err++;
    endtask

    task automatic step(input bit b);
        pwm_in = b;
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic sched(input int c, input int v, input bit f);
        exp_s[c] = 8'(v);
        exp_f[c] = f;
    endtask

    // a frame starts with a rise; that rise closes the previous frame
    task automatic frame(input int l, input int h);
        if (have_prev) sched(cyc + 3, frame_val(prev_h), prev_l != PERIOD);
        prev_l    = l;
        prev_h    = h;
        have_prev = 1'b1;
        for (int i = 0; i < l; i++) step(i < h);
    endtask

    task automatic do_reset();
        gated_reset = 1'b0;
        #1;
        mdl_valid  = 1'b0;
        mdl_sample = 8'd0;
        mdl_err    = 0;
        have_prev  = 1'b0;
        exp_s.delete();
        exp_f.delete();
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample", 32'(sample_out), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        repeat (3) step(1'b0);
        gated_reset = 1'b1;
    endtask

    initial begin
        int l, h, e;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", 32'(sample_valid), 32'd0);
        chk("init_sample", 32'(sample_out), 32'd0);
        chk("init_errcnt", 32'(err_count), 32'd0);
        gated_reset = 1'b1;
        repeat (3) step(1'b0);

        // 25% duty, ready held high
        repeat (4) frame(PERIOD, 64);
        repeat (6) frame(PERIOD, $urandom_range(1, PERIOD - 1));
        repeat (6) begin
            l = $urandom_range(100, 400);
            h = $urandom_range(1, l - 1);
            frame(l, h);
        end
        frame(300, 299);
        frame(PERIOD, 1);

        // short frames: 200 cycles, 100 high
        repeat (4) frame(200, 100);

        // consumer stalled for three 50% frames
        do_reset();
        sample_ready = 1'b0;
        repeat (4) frame(PERIOD, 128);
        sample_ready = 1'b1;
        repeat (5) step(1'b0);

        // reset in the middle of a frame
        do_reset();
        repeat (2) frame(PERIOD, 64);
        sched(cyc + 3, frame_val(prev_h), prev_l != PERIOD);
        for (int i = 0; i < 100; i++) step(i < 64);
        do_reset();
        frame(PERIOD, 64);
        frame(PERIOD, 64);
        frame(PERIOD, 32);

        // line stuck high, then recovery, then stuck low
        do_reset();
        frame(PERIOD, 64);
        e = cyc + 1;
        sched(e + 2, 64, 1'b0);
        sched(e + 2 + TIMEOUT, 255, 1'b1);
        for (int k = 1; k <= 3; k++) sched(e + 2 + TIMEOUT + k * PERIOD, 255, 1'b0);
        repeat (TIMEOUT + 3 * PERIOD + 5) step(1'b1);
        repeat (10) step(1'b0);
        have_prev = 1'b0;
        frame(PERIOD, 64);
        frame(PERIOD, 64);
        e = cyc + 1;
        frame(PERIOD, 10);
        sched(e + 2 + TIMEOUT, 0, 1'b1);
        sched(e + 2 + TIMEOUT + PERIOD, 0, 1'b0);
        while (cyc < e + TIMEOUT + PERIOD + 10) step(1'b0);

        // 300 bad-length frames drive the error counter into saturation
        do_reset();
        repeat (300) frame(20, $urandom_range(1, 19));
        repeat (4) step(1'b0);
`ifdef PWM_DEC_ERRCNT_EN
        chk("errcnt_sat", 32'(err_count), 32'd255);
`else
        chk("errcnt_off", 32'(err_count), 32'd0);
`endif
        chk("exp_drained", 32'(exp_s.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
